// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Control-unit to memory-responder strobe and data bundle.
//   master : control side (drives MARin, MDRin, Read, Write, BusMuxOut)
//   slave  : responder side (drives MDataOut, MemDone, Busy, ProtErr)
//   MARin     - load MAR from the low address bits of BusMuxOut
//   MDRin     - load MDR from BusMuxOut
//   Read      - read request level (four-phase)
//   Write     - write request level (four-phase)
//   BusMuxOut - bus value
//   MDataOut  - current MDR contents
//   MemDone   - request complete, held until Read and Write are both low
//   Busy      - responder not idle
//   ProtErr   - one-cycle pulse on a simultaneous Read and Write
interface mem_responder_if #(
  parameter int DATA_W = 32
);
  logic              MARin;
  logic              MDRin;
  logic              Read;
  logic              Write;
  logic [DATA_W-1:0] BusMuxOut;
  logic [DATA_W-1:0] MDataOut;
  logic              MemDone;
  logic              Busy;
  logic              ProtErr;

  modport master (
    output MARin, MDRin, Read, Write, BusMuxOut,
    input  MDataOut, MemDone, Busy, ProtErr
  );

  modport slave (
    input  MARin, MDRin, Read, Write, BusMuxOut,
    output MDataOut, MemDone, Busy, ProtErr
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder: owns MAR, MDR and a word-addressed RAM, services
//   read/write requests after WAIT_STATES wait cycles and completes them with
//   a four-phase MemDone handshake.
//   Clock - system clock, rising edge
//   Reset - asynchronous active-low reset
//   bus   - mem_responder_if.slave (strobes, bus data, MDataOut, status)
//   Every RAM word starts at zero at elaboration. Reset never touches RAM
//   contents.
module mem_responder #(
  parameter int    ADDR_W      = 9,
  parameter int    DATA_W      = 32,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = "mem_init.hex"
) (
  input  logic           Clock,
  input  logic           Reset,
  mem_responder_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic              op_write, op_write_d;
  logic [ADDR_W-1:0] mar, mar_d;
  logic [ADDR_W-1:0] addr_q, addr_q_d;
  logic [DATA_W-1:0] mdr, mdr_d;
  logic [DATA_W-1:0] wdata_q, wdata_q_d;
  logic              prot_err, prot_err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // State and register update
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_write <= 1'b0;
      mar      <= '0;
      addr_q   <= '0;
      mdr      <= '0;
      wdata_q  <= '0;
      prot_err <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      op_write <= op_write_d;
      mar      <= mar_d;
      addr_q   <= addr_q_d;
      mdr      <= mdr_d;
      wdata_q  <= wdata_q_d;
      prot_err <= prot_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    op_write_d = op_write;
    mar_d      = mar;
    addr_q_d   = addr_q;
    mdr_d      = mdr;
    wdata_q_d  = wdata_q;
    prot_err_d = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (bus.MARin) mar_d = bus.BusMuxOut[ADDR_W-1:0];
        if (bus.MDRin && !bus.Read) mdr_d = bus.BusMuxOut;
        if (bus.Read ^ bus.Write) begin
          op_write_d = bus.Write;
          addr_q_d   = mar;
          wdata_q_d  = mdr;
          cnt_d      = WAIT_INIT;
          state_d    = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
        end else if (bus.Read && bus.Write) begin
          prot_err_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_d = S_ACCESS;
        else             cnt_d   = cnt - 4'd1;
      end
      S_ACCESS: begin
        if (!op_write) mdr_d = mem[addr_q];
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!bus.Read && !bus.Write) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RAM write port; only reachable from ACCESS, which reset leaves at once
  always_ff @(posedge Clock) begin
    if (state == S_ACCESS && op_write) mem[addr_q] <= wdata_q;
  end

  assign bus.MDataOut = mdr;
  assign bus.MemDone  = (state == S_DONE);
  assign bus.Busy     = (state != S_IDLE);
  assign bus.ProtErr  = prot_err;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic Clock;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  mem_responder_if #(.DATA_W(32)) if0 ();
  mem_responder_if #(.DATA_W(32)) if1 ();

  mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(2)) u0 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (if0.slave)
  );

  mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(0)) u1 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (if1.slave)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit d, input logic marin, input logic mdrin,
                       input logic rd, input logic wr, input logic [31:0] bmo);
    if (!d) begin
      if0.MARin = marin; if0.MDRin = mdrin; if0.Read = rd; if0.Write = wr; if0.BusMuxOut = bmo;
    end else begin
      if1.MARin = marin; if1.MDRin = mdrin; if1.Read = rd; if1.Write = wr; if1.BusMuxOut = bmo;
    end
  endtask

  task automatic cycle();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [31:0] mdo(input bit d);
    return d ? if1.MDataOut : if0.MDataOut;
  endfunction
  function automatic logic done(input bit d);
    return d ? if1.MemDone : if0.MemDone;
  endfunction
  function automatic logic busy(input bit d);
    return d ? if1.Busy : if0.Busy;
  endfunction
  function automatic logic perr(input bit d);
    return d ? if1.ProtErr : if0.ProtErr;
  endfunction

  task automatic load_mar(input bit d, input logic [31:0] v);
    drive(d, 1'b1, 1'b0, 1'b0, 1'b0, v);
    cycle();
    drive(d, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic load_mdr(input bit d, input logic [31:0] v);
    drive(d, 1'b0, 1'b1, 1'b0, 1'b0, v);
    cycle();
    drive(d, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Raise Read or Write and count edges until MemDone (bounded at 20).
  task automatic run_req(input bit d, input bit wr, output int n);
    drive(d, 1'b0, 1'b0, !wr, wr, 32'h0);
    n = 0;
    do begin
      cycle();
      n++;
    end while (done(d) !== 1'b1 && n < 20);
  endtask

  task automatic end_req(input bit d);
    drive(d, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
  endtask

  task automatic test_reset();
    #12;
    total++; if (mdo(0) !== 32'h0) begin bad++; $display("FAIL reset_mdo got=%h exp=%h", mdo(0), 32'h0); end
    total++; if (done(0) !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done(0)); end
    total++; if (busy(0) !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy(0)); end
    total++; if (perr(0) !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", perr(0)); end
    @(posedge Clock);
    #3 Reset = 1'b1;
    cycle();
  endtask

  task automatic test_write_read();
    int n;
    load_mar(0, 32'h5);
    load_mdr(0, 32'hDEADBEEF);
    total++; if (mdo(0) !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_mdr_load got=%h exp=%h", mdo(0), 32'hDEADBEEF); end
    run_req(0, 1'b1, n);
    total++; if (n !== 4) begin bad++; $display("FAIL wr_latency got=%0d exp=4", n); end
    total++; if (busy(0) !== 1'b1) begin bad++; $display("FAIL wr_busy_done got=%b exp=1", busy(0)); end
    end_req(0);
    total++; if (busy(0) !== 1'b0) begin bad++; $display("FAIL wr_busy_fall got=%b exp=0", busy(0)); end
    total++; if (done(0) !== 1'b0) begin bad++; $display("FAIL wr_done_fall got=%b exp=0", done(0)); end
    load_mdr(0, 32'h0);
    total++; if (mdo(0) !== 32'h0) begin bad++; $display("FAIL rd_mdr_clear got=%h exp=0", mdo(0)); end
    run_req(0, 1'b0, n);
    total++; if (n !== 4) begin bad++; $display("FAIL rd_latency got=%0d exp=4", n); end
    total++; if (mdo(0) !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=%h", mdo(0), 32'hDEADBEEF); end
    end_req(0);
  endtask

  task automatic test_illegal();
    int n;
    load_mdr(0, 32'h1111);
    drive(0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    cycle();
    total++; if (perr(0) !== 1'b1) begin bad++; $display("FAIL ill_perr_high got=%b exp=1", perr(0)); end
    total++; if (busy(0) !== 1'b0) begin bad++; $display("FAIL ill_busy got=%b exp=0", busy(0)); end
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    total++; if (perr(0) !== 1'b0) begin bad++; $display("FAIL ill_perr_low got=%b exp=0", perr(0)); end
    total++; if (busy(0) !== 1'b0) begin bad++; $display("FAIL ill_busy_after got=%b exp=0", busy(0)); end
    run_req(0, 1'b0, n);
    total++; if (mdo(0) !== 32'hDEADBEEF) begin bad++; $display("FAIL ill_ram_kept got=%h exp=%h", mdo(0), 32'hDEADBEEF); end
    end_req(0);
  endtask

  task automatic test_frozen_and_hold();
    int n;
    load_mdr(0, 32'h0);
    drive(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle();
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10);
    cycle();
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1234);
    cycle();
    drive(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle();
    total++; if (done(0) !== 1'b1) begin bad++; $display("FAIL frz_done got=%b exp=1", done(0)); end
    total++; if (mdo(0) !== 32'hDEADBEEF) begin bad++; $display("FAIL frz_data got=%h exp=%h", mdo(0), 32'hDEADBEEF); end
    for (int i = 0; i < 6; i++) begin
      cycle();
      total++; if (done(0) !== 1'b1) begin bad++; $display("FAIL hold_done[%0d] got=%b exp=1", i, done(0)); end
      total++; if (mdo(0) !== 32'hDEADBEEF) begin bad++; $display("FAIL hold_data[%0d] got=%h exp=%h", i, mdo(0), 32'hDEADBEEF); end
    end
    end_req(0);
    total++; if (done(0) !== 1'b0) begin bad++; $display("FAIL hold_release_done got=%b exp=0", done(0)); end
    total++; if (busy(0) !== 1'b0) begin bad++; $display("FAIL hold_release_busy got=%b exp=0", busy(0)); end
    load_mdr(0, 32'h0);
    run_req(0, 1'b0, n);
    total++; if (mdo(0) !== 32'hDEADBEEF) begin bad++; $display("FAIL frz_mar_kept got=%h exp=%h", mdo(0), 32'hDEADBEEF); end
    end_req(0);
  endtask

  task automatic test_async_reset();
    int n;
    load_mar(0, 32'h7);
    load_mdr(0, 32'hCAFE);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    cycle();
    #2 Reset = 1'b0;
    #1;
    total++; if (mdo(0) !== 32'h0) begin bad++; $display("FAIL arst_mdo got=%h exp=0", mdo(0)); end
    total++; if (done(0) !== 1'b0) begin bad++; $display("FAIL arst_done got=%b exp=0", done(0)); end
    total++; if (busy(0) !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", busy(0)); end
    total++; if (perr(0) !== 1'b0) begin bad++; $display("FAIL arst_perr got=%b exp=0", perr(0)); end
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge Clock);
    #3 Reset = 1'b1;
    load_mar(0, 32'h7);
    load_mdr(0, 32'hFFFFFFFF);
    run_req(0, 1'b0, n);
    total++; if (n !== 4) begin bad++; $display("FAIL arst_rd_latency got=%0d exp=4", n); end
    total++; if (mdo(0) !== 32'h0) begin bad++; $display("FAIL arst_ram_kept got=%h exp=0", mdo(0)); end
    end_req(0);
  endtask

  task automatic test_wrap_zero_wait();
    int n;
    load_mar(1, 32'h205);
    load_mdr(1, 32'h55);
    run_req(1, 1'b1, n);
    total++; if (n !== 2) begin bad++; $display("FAIL z_wr_latency got=%0d exp=2", n); end
    end_req(1);
    total++; if (busy(1) !== 1'b0) begin bad++; $display("FAIL z_busy_fall got=%b exp=0", busy(1)); end
    load_mar(1, 32'h005);
    load_mdr(1, 32'h0);
    run_req(1, 1'b0, n);
    total++; if (n !== 2) begin bad++; $display("FAIL z_rd_latency got=%0d exp=2", n); end
    total++; if (mdo(1) !== 32'h55) begin bad++; $display("FAIL z_wrap_data got=%h exp=%h", mdo(1), 32'h55); end
    end_req(1);
  endtask

  task automatic test_back_to_back();
    int n;
    load_mar(0, 32'h9);
    load_mdr(0, 32'hA5A5A5A5);
    run_req(0, 1'b1, n);
    end_req(0);
    load_mdr(0, 32'h0BADF00D);
    run_req(0, 1'b1, n);
    end_req(0);
    load_mdr(0, 32'h0);
    run_req(0, 1'b0, n);
    total++; if (mdo(0) !== 32'h0BADF00D) begin bad++; $display("FAIL b2b_raw got=%h exp=%h", mdo(0), 32'h0BADF00D); end
    end_req(0);
  endtask

  initial begin
    Reset = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_write_read();
    test_illegal();
    test_frozen_and_hold();
    test_async_reset();
    test_wrap_zero_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder to the control unit's MARin/MDRin/Read/Write strobes.
- Owns the MAR and MDR registers and an internal word-addressed RAM.
- Services read and write requests with a configurable number of wait states, then signals completion over a four-phase handshake (MemDone).
- Sits between the bus mux and the MDR input of the bus encoder.

Parameters:
- ADDR_W, 9, MAR width; RAM depth = 2**ADDR_W words.
- DATA_W, 32, word width.
- WAIT_STATES, 2, wait cycles before the RAM access (0..15).
- INIT_FILE, "mem_init.hex", hex image used only when MEM_INIT_EN is defined.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- MARin  in  1  load MAR from BusMuxOut[ADDR_W-1:0].
- MDRin  in  1  load MDR from BusMuxOut (ignored while Read=1).
- Read  in  1  read request (level, four-phase).
- Write  in  1  write request (level, four-phase).
- BusMuxOut  in  DATA_W  bus value.
- MDataOut  out  DATA_W  current MDR contents, to the bus encoder.
- MemDone  out  1  request complete; held until Read and Write both low.
- Busy  out  1  high whenever state != IDLE.
- ProtErr  out  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset (Reset=0, async): state=IDLE, MAR=0, MDR=0, MemDone=0, ProtErr=0, wait counter=0. RAM contents are not cleared. Reset mid-request aborts it; no RAM write occurs after reset asserts.
- MDataOut = MDR (combinational). Busy = (state != IDLE).
- IDLE:
  - MARin=1 loads MAR at the edge.
  - MDRin=1 with Read=0 loads MDR from BusMuxOut.
  - Read xor Write high at an edge starts a request. The MAR and MDR values used are those held before that edge; a same-edge MARin/MDRin still loads but is not used by this request.
  - Next state is WAIT, with counter=WAIT_STATES-1. If WAIT_STATES=0, next state is ACCESS.
- Read and Write both high in IDLE: no request, state stays IDLE, ProtErr=1 for one cycle.
- WAIT: decrement the counter each edge; when counter==0 go to ACCESS.
- ACCESS (exactly one cycle):
  - Read: MDR <= RAM[MAR].
  - Write: RAM[MAR] <= MDR.
  - Next state is DONE.
- DONE: MemDone=1. Stay in DONE while Read or Write is high; go to IDLE at the first edge where both are low. MemDone drops on entry to IDLE.
- Latency: request sampled at edge k gives MemDone=1 after edge k+WAIT_STATES+1. This is WAIT_STATES+2 cycles after the request; with the default, 4 cycles.
- Outside IDLE:
  - MARin and MDRin are ignored, so MAR and MDR are frozen for the access.
  - A Read/Write level change before DONE is ignored; the operation latched at request start completes.
  - The ProtErr check applies only in IDLE.
- Back-to-back requests require a return to IDLE: minimum one idle cycle between MemDone falling and the next request being sampled.
- Address wrap: MAR takes BusMuxOut[ADDR_W-1:0] only; upper bits are discarded, so address 0x200 maps to word 0.
- Read-after-write to the same address in consecutive requests returns the new data.

Optional Feature:
- Macro: MEM_INIT_EN.
- Defined: RAM is preloaded at elaboration from INIT_FILE via a hex read.
- Undefined: every RAM word is initialised to 0 at elaboration.
- Reset never alters RAM in either build.

Test Plan:
- Write then read, WAIT_STATES=2:
  - BusMuxOut=0x05 with MARin; 0xDEADBEEF with MDRin; then Write=1.
  - MemDone rises 4 cycles after Write was sampled; drop Write; Busy falls 1 cycle later.
  - Load MDR=0, then Read=1: MDataOut=0xDEADBEEF when MemDone rises.
- Illegal request: Read=1 and Write=1 together in IDLE -> ProtErr pulses for exactly 1 cycle, Busy stays 0, RAM[MAR] unchanged.
- Frozen registers: during a read of address 0x05, pulse MARin with 0x10 and MDRin with 0x1234 -> ignored; read returns RAM[0x05]; afterwards MAR=0x05.
- Handshake hold: keep Read=1 for 6 cycles after MemDone -> MemDone stays 1 and no second access occurs. Drop Read -> IDLE next edge.
- Async reset in WAIT: assert Reset=0 between edges while writing 0xCAFE to address 0x07 -> all outputs 0 immediately. After release, a read of 0x07 returns the prior value (0 without MEM_INIT_EN).
- Wrap and zero wait: with WAIT_STATES=0, write 0x55 to MAR source 0x205 -> MemDone 2 cycles after request; a read of 0x005 returns 0x55.
